huff_stream_ctrl: RTL and testbench

HUFF_STREAM_CTRL -- requirements
Module: huff_stream_ctrl

---
 rtl/huff_stream_ctrl_if.sv | 26 ++
 rtl/huff_stream_ctrl.sv | 161 ++++++++++++++++
 tb/tb_huff_stream_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/huff_stream_ctrl_if.sv
// huff_stream_ctrl_if: input-word, decoder and output-symbol handshakes
// master: stream source / decoder / output sink side
// slave : huff_stream_ctrl side
interface huff_stream_ctrl_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [5:0]  dec_window;
    logic        dec_req;
    logic        dec_valid;
    logic [2:0]  dec_len;
    logic [3:0]  dec_sym;
    logic [15:0] out_data;
    logic [2:0]  out_cnt;
    logic        out_valid;
    logic        out_ready;
    modport slave (
        input  in_data, in_valid, in_last, dec_valid, dec_len, dec_sym, out_ready,
        output in_ready, dec_window, dec_req, out_data, out_cnt, out_valid
    );
    modport master (
        output in_data, in_valid, in_last, dec_valid, dec_len, dec_sym, out_ready,
        input  in_ready, dec_window, dec_req, out_data, out_cnt, out_valid
    );
endinterface

// File: rtl/huff_stream_ctrl.sv
// huff_stream_ctrl: feeds a 64-bit bit buffer to a Huffman decoder and packs symbols
// clk, rst          : clock, asynchronous active-high reset
// i_start           : begin a stream (IDLE/DONE only), i_sym_total latched
// io_bus            : in_* word stream, dec_* decoder handshake, out_* packed symbols
// o_busy/o_done/o_err/o_sym_done : status and running symbol count
// HSC_TIMEOUT_EN    : enables the decoder response timeout (TIMEOUT_CYC)
module huff_stream_ctrl #(
    parameter int TIMEOUT_CYC = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_sym_total,
    huff_stream_ctrl_if.slave io_bus,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [CNT_W-1:0] o_sym_done
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_REQ, S_WAIT, S_EMIT, S_DONE} state_t;
    state_t           r_state;
    logic [63:0]      r_buf;
    logic [6:0]       r_bcnt;
    logic             r_last;
    logic [15:0]      r_pack;
    logic [2:0]       r_pcnt;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_sym;
    logic             r_err;
    logic             r_dec_req;
    logic [5:0]       r_win;
    logic [15:0]      r_out_data;
    logic [2:0]       r_out_cnt;
    logic             r_out_valid;
`ifdef HSC_TIMEOUT_EN
    logic [31:0]      r_tcnt;
`endif
    logic             w_active, w_in_ready, w_in_fire, w_len_bad, w_take, w_space, w_starve, w_go;
    logic [6:0]       w_len, w_bcnt_s, w_bcnt_n;
    logic [63:0]      w_buf_s, w_buf_n;
    logic [15:0]      w_pack_n;
    logic [CNT_W-1:0] w_sym_n;
    // Bits below bcnt are always zero, so the window needs no explicit padding mask.
    always_comb begin
        w_active   = r_state != S_IDLE && r_state != S_DONE;
        w_in_ready = w_active && r_bcnt <= 7'd32 && !r_last;
        w_in_fire  = w_in_ready && io_bus.in_valid;
        w_len      = {4'd0, io_bus.dec_len};
        w_len_bad  = io_bus.dec_len == 3'd0 || w_len > r_bcnt;
        w_take     = r_state == S_WAIT && io_bus.dec_valid && !w_len_bad;
        // consume first, then append the new word directly below the remaining bits
        w_buf_s    = w_take ? r_buf << io_bus.dec_len : r_buf;
        w_bcnt_s   = w_take ? r_bcnt - w_len : r_bcnt;
        w_buf_n    = w_in_fire ? w_buf_s | ({io_bus.in_data, 32'd0} >> w_bcnt_s) : w_buf_s;
        w_bcnt_n   = w_in_fire ? w_bcnt_s + 7'd32 : w_bcnt_s;
        w_pack_n   = r_pack | ({io_bus.dec_sym, 12'd0} >> {r_pcnt, 2'b00});
        w_sym_n    = r_sym + CNT_W'(1);
        w_space    = !r_out_valid || r_pcnt != 3'd4;
        w_starve   = r_last && r_bcnt == 7'd0 && r_sym < r_total;
        w_go       = w_space && (r_bcnt >= 7'd6 || (r_last && r_bcnt != 7'd0));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_buf       <= '0;
            r_bcnt      <= '0;
            r_last      <= 1'b0;
            r_pack      <= '0;
            r_pcnt      <= '0;
            r_total     <= '0;
            r_sym       <= '0;
            r_err       <= 1'b0;
            r_dec_req   <= 1'b0;
            r_win       <= '0;
            r_out_data  <= '0;
            r_out_cnt   <= '0;
            r_out_valid <= 1'b0;
`ifdef HSC_TIMEOUT_EN
            r_tcnt      <= '0;
`endif
        end else begin
            r_buf     <= w_buf_n;
            r_bcnt    <= w_bcnt_n;
            r_dec_req <= 1'b0;
            if (w_in_fire && io_bus.in_last) r_last <= 1'b1;
            case (r_state)
                S_IDLE, S_DONE: if (i_start) begin
                    r_buf   <= '0;
                    r_bcnt  <= '0;
                    r_last  <= 1'b0;
                    r_pack  <= '0;
                    r_pcnt  <= '0;
                    r_sym   <= '0;
                    r_err   <= 1'b0;
                    r_total <= i_sym_total;
                    r_state <= i_sym_total == '0 ? S_DONE : S_FETCH;
                end
                S_FETCH: if (w_starve) begin
                    // stream ran dry early: flag it and flush whatever is packed
                    r_err <= 1'b1;
                    if (r_pcnt != 3'd0) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_pack;
                        r_out_cnt   <= r_pcnt;
                        r_state     <= S_EMIT;
                    end else r_state <= S_DONE;
                end else if (w_go) r_state <= S_REQ;
                S_REQ: begin
                    r_dec_req <= 1'b1;
                    r_win     <= r_buf[63:58];
                    r_state   <= S_WAIT;
`ifdef HSC_TIMEOUT_EN
                    r_tcnt    <= '0;
`endif
                end
                S_WAIT: if (io_bus.dec_valid) begin
                    if (w_len_bad) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_pack <= w_pack_n;
                        r_pcnt <= r_pcnt + 3'd1;
                        r_sym  <= w_sym_n;
                        if (r_pcnt == 3'd3 || w_sym_n == r_total) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_pack_n;
                            r_out_cnt   <= r_pcnt + 3'd1;
                            r_state     <= S_EMIT;
                        end else r_state <= S_FETCH;
                    end
                end
`ifdef HSC_TIMEOUT_EN
                else if (r_tcnt == 32'(TIMEOUT_CYC - 1)) begin
                    r_err   <= 1'b1;
                    r_state <= S_DONE;
                end else r_tcnt <= r_tcnt + 32'd1;
`endif
                S_EMIT: if (io_bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_out_cnt   <= '0;
                    r_pack      <= '0;
                    r_pcnt      <= '0;
                    r_state     <= (r_err || r_sym == r_total) ? S_DONE : S_FETCH;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign io_bus.in_ready   = w_in_ready;
    assign io_bus.dec_window = r_win;
    assign io_bus.dec_req    = r_dec_req;
    assign io_bus.out_data   = r_out_data;
    assign io_bus.out_cnt    = r_out_cnt;
    assign io_bus.out_valid  = r_out_valid;
    assign o_busy            = w_active;
    assign o_done            = r_state == S_DONE;
    assign o_err             = r_err;
    assign o_sym_done        = r_sym;
endmodule

// File: tb/tb_huff_stream_ctrl.sv
// tb_huff_stream_ctrl: directed checks of huff_stream_ctrl acting as source, decoder and sink
module tb_huff_stream_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] sym_total = '0;
    logic        busy, done, err;
    logic [15:0] sym_done;
    int          total = 0;
    int          bad = 0;
    huff_stream_ctrl_if io ();
    huff_stream_ctrl dut (
        .clk(clk), .rst(rst), .i_start(start), .i_sym_total(sym_total), .io_bus(io),
        .o_busy(busy), .o_done(done), .o_err(err), .o_sym_done(sym_done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic go(input logic [15:0] n);
        start = 1'b1;
        sym_total = n;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic feed(input logic [31:0] w, input logic last);
        int n = 0;
        io.in_data = w;
        io.in_last = last;
        io.in_valid = 1'b1;
        while (!io.in_ready && n < 50) begin @(negedge clk); n++; end
        chk("in_ready", io.in_ready, 1);
        @(negedge clk);
        io.in_valid = 1'b0;
        io.in_last = 1'b0;
    endtask
    task automatic dec(input string tag, input logic [5:0] win, input logic [2:0] len, input logic [3:0] sym);
        int n = 0;
        while (!io.dec_req && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_req"}, io.dec_req, 1);
        chk({tag, "_win"}, io.dec_window, win);
        io.dec_valid = 1'b1;
        io.dec_len = len;
        io.dec_sym = sym;
        @(negedge clk);
        io.dec_valid = 1'b0;
    endtask
    task automatic emit(input string tag, input logic [15:0] d, input logic [2:0] c, input int hold);
        int n = 0;
        while (!io.out_valid && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, io.out_valid, 1);
        chk({tag, "_data"}, io.out_data, d);
        chk({tag, "_cnt"}, io.out_cnt, c);
        for (int i = 0; i < hold; i++) begin
            io.dec_valid = 1'b1;
            io.dec_len = 3'd1;
            @(negedge clk);
            chk({tag, "_hold_data"}, io.out_data, d);
            chk({tag, "_hold_req"}, io.dec_req, 0);
        end
        io.dec_valid = 1'b0;
        io.out_ready = 1'b1;
        @(negedge clk);
        io.out_ready = 1'b0;
    endtask
    task automatic zeros(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_symd"}, sym_done, 0);
        chk({tag, "_inrdy"}, io.in_ready, 0);
        chk({tag, "_req"}, io.dec_req, 0);
        chk({tag, "_ov"}, io.out_valid, 0);
        chk({tag, "_od"}, io.out_data, 0);
        chk({tag, "_oc"}, io.out_cnt, 0);
    endtask
    initial begin
        io.in_data = '0; io.in_valid = 1'b0; io.in_last = 1'b0;
        io.dec_valid = 1'b0; io.dec_len = '0; io.dec_sym = '0; io.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        zeros("reset");
        rst = 1'b0;
        @(negedge clk);
        // four 1-bit codes from one last word
        go(16'd4);
        chk("s1_busy", busy, 1);
        feed(32'hF0000000, 1'b1);
        dec("s1a", 6'h3C, 3'd1, 4'h0);
        dec("s1b", 6'h38, 3'd1, 4'h0);
        dec("s1c", 6'h30, 3'd1, 4'h0);
        dec("s1d", 6'h20, 3'd1, 4'h0);
        chk("s1_symd", sym_done, 4);
        emit("s1_out", 16'h0000, 3'd4, 0);
        chk("s1_done", done, 1);
        chk("s1_err", err, 0);
        chk("s1_ov", io.out_valid, 0);
        // 6-bit codes, the sixth straddles the word boundary; output stalled 10 cycles
        go(16'd6);
        feed(32'h0420C417, 1'b0);
        feed(32'h60000000, 1'b1);
        dec("s2a", 6'h01, 3'd6, 4'h1);
        dec("s2b", 6'h02, 3'd6, 4'h2);
        dec("s2c", 6'h03, 3'd6, 4'h3);
        dec("s2d", 6'h04, 3'd6, 4'h4);
        emit("s2_out1", 16'h1234, 3'd4, 10);
        chk("s2_symd_hold", sym_done, 4);
        dec("s2e", 6'h05, 3'd6, 4'h5);
        dec("s2f", 6'h36, 3'd6, 4'h6);
        emit("s2_out2", 16'h5600, 3'd2, 0);
        chk("s2_done", done, 1);
        chk("s2_symd", sym_done, 6);
        // tail of 3 bits is padded with zeros in the window
        go(16'd6);
        feed(32'h00000005, 1'b1);
        dec("s3a", 6'h00, 3'd6, 4'h1);
        dec("s3b", 6'h00, 3'd6, 4'h2);
        dec("s3c", 6'h00, 3'd6, 4'h3);
        dec("s3d", 6'h00, 3'd6, 4'h4);
        emit("s3_out1", 16'h1234, 3'd4, 0);
        dec("s3e", 6'h01, 3'd5, 4'h5);
        dec("s3f", 6'h28, 3'd3, 4'h6);
        chk("s3_bcnt", 32'(dut.r_bcnt), 0);
        emit("s3_out2", 16'h5600, 3'd2, 0);
        chk("s3_done", done, 1);
        chk("s3_err", err, 0);
        // code length longer than the remaining bits
        go(16'd8);
        chk("s4_err_clr", err, 0);
        feed(32'hFFFFFFFF, 1'b1);
        dec("s4a", 6'h3F, 3'd6, 4'h1);
        dec("s4b", 6'h3F, 3'd6, 4'h2);
        dec("s4c", 6'h3F, 3'd6, 4'h3);
        dec("s4d", 6'h3F, 3'd6, 4'h4);
        emit("s4_out", 16'h1234, 3'd4, 0);
        dec("s4e", 6'h3F, 3'd6, 4'h5);
        dec("s4f", 6'h30, 3'd5, 4'h6);
        chk("s4_err", err, 1);
        chk("s4_done", done, 1);
        chk("s4_ov", io.out_valid, 0);
        chk("s4_symd", sym_done, 5);
        // stream exhausted before sym_total: error plus flush of packed nibbles
        go(16'd7);
        chk("s5_err_clr", err, 0);
        feed(32'hFFFFFFFF, 1'b1);
        dec("s5a", 6'h3F, 3'd6, 4'h1);
        dec("s5b", 6'h3F, 3'd6, 4'h2);
        dec("s5c", 6'h3F, 3'd6, 4'h3);
        dec("s5d", 6'h3F, 3'd6, 4'h4);
        emit("s5_out1", 16'h1234, 3'd4, 0);
        dec("s5e", 6'h3F, 3'd6, 4'h5);
        dec("s5f", 6'h30, 3'd2, 4'h6);
        emit("s5_out2", 16'h5600, 3'd2, 0);
        chk("s5_err", err, 1);
        chk("s5_done", done, 1);
        chk("s5_symd", sym_done, 6);
`ifdef HSC_TIMEOUT_EN
        // decoder never answers
        go(16'd1);
        feed(32'hFFFFFFFF, 1'b1);
        for (int n = 0; n < 50 && !io.dec_req; n++) @(negedge clk);
        chk("to_req", io.dec_req, 1);
        repeat (12) @(negedge clk);
        chk("to_err", err, 1);
        chk("to_done", done, 1);
        chk("to_ov", io.out_valid, 0);
`endif
        // reset while waiting on the decoder, then an empty stream
        go(16'd3);
        feed(32'hFFFFFFFF, 1'b1);
        for (int n = 0; n < 50 && !io.dec_req; n++) @(negedge clk);
        chk("s6_req", io.dec_req, 1);
        rst = 1'b1;
        #1;
        zeros("s6_rst");
        @(negedge clk);
        rst = 1'b0;
        go(16'd0);
        chk("s6_done", done, 1);
        chk("s6_busy", busy, 0);
        chk("s6_err", err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
